// File: rtl/game_pkg.sv
// Shared game-logic types: GameController states and frame scheduler FSM states.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } sched_state_t;

    localparam logic [7:0] STAT_MAX = 8'hFF;

endpackage

// File: rtl/sched_watchdog.sv
// Per-entity watchdog: cleared on each grant, counts while waiting, flags the last allowed cycle.
module sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (enable) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = (timer == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/frame_update_scheduler.sv
// Sequences per-frame entity updates during vertical blank with a per-entity watchdog.
// Optional statistics counters are enabled by defining FRAME_SCHED_STATS_EN.
module frame_update_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_ENTITIES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [1:0]  PLAY_STATE     = 2'b01
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    vs,
    input  logic [1:0]              gameState,
    input  logic [NUM_ENTITIES-1:0] upd_done,
    output logic [NUM_ENTITIES-1:0] upd_req,
    output logic                    busy,
    output logic                    frame_tick,
    output logic                    overrun,
    output logic                    timeout,
    output logic [7:0]              overrun_count,
    output logic [7:0]              timeout_count
);

    localparam int unsigned IW = $clog2(NUM_ENTITIES);

    sched_state_t  state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          vs_q;
    logic          busy_q;
    logic          vblank_start;
    logic          playing;
    logic          done_hit;
    logic          last_entity;
    logic          wd_clear;
    logic          wd_enable;
    logic          wd_expired;

    assign vblank_start = vs_q & ~vs;
    assign playing      = (gameState == PLAY_STATE);
    assign done_hit     = upd_done[idx];
    assign last_entity  = (idx == IW'(NUM_ENTITIES - 1));
    assign overrun      = vblank_start && (state != IDLE);
    assign busy         = busy_q;

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            vs_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            vs_q   <= vs;
            busy_q <= (state_nxt != IDLE);
        end
    end

    // Leaving PLAY in any active state drops straight to IDLE and suppresses that cycle's pulses.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        upd_req    = '0;
        frame_tick = 1'b0;
        timeout    = 1'b0;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        case (state)
            IDLE: begin
                if (vblank_start && playing) begin
                    idx_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!playing) begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    upd_req[idx] = 1'b1;
                    wd_clear     = 1'b1;
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (!playing) begin
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    wd_enable = 1'b1;
                    if (done_hit || wd_expired) begin
                        timeout = ~done_hit;
                        if (last_entity) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = idx + IW'(1);
                            state_nxt = ISSUE;
                        end
                    end
                end
            end
            DONE: begin
                frame_tick = playing;
                idx_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef FRAME_SCHED_STATS_EN
    logic [7:0] ovr_cnt;
    logic [7:0] to_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ovr_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (overrun && (ovr_cnt != STAT_MAX)) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
            if (timeout && (to_cnt != STAT_MAX)) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

    assign overrun_count = ovr_cnt;
    assign timeout_count = to_cnt;
`else
    assign overrun_count = '0;
    assign timeout_count = '0;
`endif

endmodule
